// File: rtl/mem_access_stage.sv
// Registered MEM stage: latches EX results, runs load/store on a req/ack
// data-memory port, steers store lanes and formats load data.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ALUresult_i,
  input  logic [31:0] WriteData_i,
  input  logic [4:0]  INS_11_7_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        valid_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ALUresult_o,
  output logic [31:0] Readdata_o,
  output logic [4:0]  INS_11_7_o,
  output logic        err_o
);

  // state | meaning
  // IDLE  | accepting EX: pass-through, bubbles, rejected memory ops
  // BUSY  | request outstanding, waiting for mem_ack_i or timeout
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  state_t        r_state;
  logic [TW-1:0] r_tmr;
  logic [2:0]    r_f3;
  logic [1:0]    r_lane;
  logic          r_rw;
  logic          r_m2r;
  logic [4:0]    r_rd;
  logic [31:0]   r_alu;

  logic        w_mem_op;
  logic        w_f3_ok;
  logic        w_misalign;
  logic        w_legal;
  logic        w_accept;
  logic        w_tmo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_mem_op = MemRead_i | MemWrite_i;

  always_comb begin
    w_f3_ok = 1'b0;
    if (MemWrite_i)
      w_f3_ok = ~funct3_i[2] & (funct3_i[1:0] != 2'b11);
    else
      w_f3_ok = (funct3_i != 3'b011) & (funct3_i[2:1] != 2'b11);
  end

  assign w_misalign = ((funct3_i[1:0] == 2'b01) & ALUresult_i[0]) |
                      ((funct3_i[1:0] == 2'b10) & (ALUresult_i[1:0] != 2'b00));
  assign w_legal  = w_f3_ok & ~w_misalign;
  assign w_accept = (r_state == IDLE) & valid_i & w_mem_op & w_legal;
  // An ack in the terminal-count cycle wins over the timeout.
  assign w_tmo    = (r_state == BUSY) & ~mem_ack_i & (r_tmr == '0);
  assign stall_o  = w_accept | ((r_state == BUSY) & ~mem_ack_i & ~w_tmo);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteData_i;
    case (funct3_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ALUresult_i[1:0];
        w_wdata = {4{WriteData_i[7:0]}};
      end
      2'b01: begin
        w_be    = ALUresult_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteData_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = mem_rdata_i[7:0];
    case (r_lane)
      2'd1:    w_byte = mem_rdata_i[15:8];
      2'd2:    w_byte = mem_rdata_i[23:16];
      2'd3:    w_byte = mem_rdata_i[31:24];
      default: ;
    endcase
    w_half = r_lane[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (r_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'h0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_tmr       <= '0;
      r_f3        <= '0;
      r_lane      <= '0;
      r_rw        <= 1'b0;
      r_m2r       <= 1'b0;
      r_rd        <= '0;
      r_alu       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      valid_o     <= 1'b0;
      RegWrite_o  <= 1'b0;
      MemtoReg_o  <= 1'b0;
      ALUresult_o <= '0;
      Readdata_o  <= '0;
      INS_11_7_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      RegWrite_o <= 1'b0;
      err_o      <= 1'b0;
      if (r_state == IDLE) begin
        if (valid_i && !w_mem_op) begin
          valid_o     <= 1'b1;
          RegWrite_o  <= RegWrite_i;
          MemtoReg_o  <= MemtoReg_i;
          ALUresult_o <= ALUresult_i;
          INS_11_7_o  <= INS_11_7_i;
          Readdata_o  <= '0;
        end else if (valid_i && !w_legal) begin
          valid_o     <= 1'b1;
          err_o       <= 1'b1;
          MemtoReg_o  <= MemtoReg_i;
          ALUresult_o <= ALUresult_i;
          INS_11_7_o  <= INS_11_7_i;
          Readdata_o  <= '0;
        end else if (w_accept) begin
          r_state     <= BUSY;
          r_tmr       <= TMR_LOAD;
          r_f3        <= funct3_i;
          r_lane      <= ALUresult_i[1:0];
          r_rw        <= RegWrite_i;
          r_m2r       <= MemtoReg_i;
          r_rd        <= INS_11_7_i;
          r_alu       <= ALUresult_i;
          mem_req_o   <= 1'b1;
          mem_we_o    <= MemWrite_i;
          mem_addr_o  <= {ALUresult_i[31:2], 2'b00};
          mem_be_o    <= w_be;
          mem_wdata_o <= w_wdata;
        end
      end else begin
        if (mem_ack_i || w_tmo) begin
          r_state     <= IDLE;
          mem_req_o   <= 1'b0;
          valid_o     <= 1'b1;
          MemtoReg_o  <= r_m2r;
          ALUresult_o <= r_alu;
          INS_11_7_o  <= r_rd;
          RegWrite_o  <= mem_ack_i & r_rw & ~mem_we_o;
          Readdata_o  <= (mem_ack_i && !mem_we_o) ? w_load : 32'h0;
          err_o       <= ~mem_ack_i;
        end else begin
          r_tmr <= r_tmr - TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM/WB results are queued at
// issue and checked on each valid_o pulse; a small memory model drives the ack.
module tb_mem_access_stage;

  logic        clk_i, rst_i;
  logic        valid_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [2:0]  funct3_i;
  logic [31:0] ALUresult_i, WriteData_i;
  logic [4:0]  INS_11_7_i;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        valid_o, RegWrite_o, MemtoReg_o;
  logic [31:0] ALUresult_o, Readdata_o;
  logic [4:0]  INS_11_7_o;
  logic        err_o;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .funct3_i(funct3_i), .ALUresult_i(ALUresult_i), .WriteData_i(WriteData_i),
    .INS_11_7_i(INS_11_7_i), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .valid_o(valid_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .ALUresult_o(ALUresult_o), .Readdata_o(Readdata_o),
    .INS_11_7_o(INS_11_7_o), .err_o(err_o)
  );

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc = 0, acc_cyc = 0, lat = 0;
  int busy_n = 0, ack_dly = -1;
  int stall_cnt = 0, req_cnt = 0, err_cnt = 0;
  logic spur = 1'b0;
  logic [31:0] rdata_val = '0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lane,
                                         input logic [31:0] w);
    logic [31:0] s;
    logic [7:0]  b;
    logic [15:0] h;
    s = w >> (8 * lane);
    b = s[7:0];
    h = s[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] lane);
    if (sz == 2'd0) return 4'b0001 << lane;
    if (sz == 2'd1) return (lane == 2'd2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return {4{wd[7:0]}};
    if (sz == 2'd1) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic exp_t mk(input logic rw, input logic m2r, input logic [31:0] alu,
                              input logic [4:0] rd, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rw = rw; e.m2r = m2r; e.alu = alu; e.rd = rd; e.rdata = rdata; e.err = err;
    return e;
  endfunction

  // memory model and output monitor
  always @(negedge clk_i) begin
    exp_t e;
    cyc++;
    if (mem_req_o) begin
      busy_n++;
      mem_ack_i = spur || (ack_dly >= 0 && busy_n == ack_dly + 1);
      mem_rdata_i = mem_ack_i ? rdata_val : 32'hDEAD_BEEF;
    end else begin
      busy_n = 0;
      mem_ack_i = spur;
    end
    #1;
    if (stall_o) stall_cnt++;
    if (err_o) err_cnt++;
    if (mem_req_o) begin
      req_cnt++;
      if (busy_n == 1) begin
        cap_addr = mem_addr_o; cap_wdata = mem_wdata_o; cap_be = mem_be_o; cap_we = mem_we_o;
      end else begin
        check("req_stable", {mem_addr_o[31:2], mem_be_o[1:0]}, {cap_addr[31:2], cap_be[1:0]});
      end
    end
    if (valid_o) begin
      lat = cyc - acc_cyc;
      if (sb.size() == 0) begin
        check("valid_unexpected", 32'(valid_o), 32'd0);
      end else begin
        e = sb.pop_front();
        check("RegWrite_o", 32'(RegWrite_o), 32'(e.rw));
        check("MemtoReg_o", 32'(MemtoReg_o), 32'(e.m2r));
        check("ALUresult_o", ALUresult_o, e.alu);
        check("INS_11_7_o", 32'(INS_11_7_o), 32'(e.rd));
        check("Readdata_o", Readdata_o, e.rdata);
        check("err_o", 32'(err_o), 32'(e.err));
      end
    end
  end

  task automatic issue(input logic mr, input logic mw, input logic rw, input logic m2r,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] rdv, input int dly);
    logic s;
    int guard;
    @(posedge clk_i); #1;
    rdata_val = rdv; ack_dly = dly;
    stall_cnt = 0; req_cnt = 0; err_cnt = 0; lat = -1;
    cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
    valid_i = 1'b1; MemRead_i = mr; MemWrite_i = mw; RegWrite_i = rw; MemtoReg_i = m2r;
    funct3_i = f3; ALUresult_i = addr; WriteData_i = wd; INS_11_7_i = rd;
    acc_cyc = cyc + 1;
    guard = 0;
    do begin
      @(negedge clk_i); #2;
      s = stall_o;
      @(posedge clk_i); #1;
      guard++;
    end while (s && guard < 64);
    valid_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; RegWrite_i = 1'b0;
    if (guard >= 64) check("stall_bound", 32'(guard), 32'd0);
  endtask

  task automatic settle();
    int g;
    g = 0;
    while ((sb.size() != 0 || mem_req_o) && g < 50) begin
      @(negedge clk_i); g++;
    end
    @(negedge clk_i); #2;
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [1:0]  lane;
    logic [31:0] a, w;
    int d;
    logic [2:0] ld_f3 [5];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    rst_i = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = '0;
    valid_i = 0; RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0;
    funct3_i = '0; ALUresult_i = '0; WriteData_i = '0; INS_11_7_i = '0;
    repeat (2) @(negedge clk_i);
    #2;
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_mem_req_o", 32'(mem_req_o), 32'd0);
    check("rst_stall_o", 32'(stall_o), 32'd0);
    check("rst_err_o", 32'(err_o), 32'd0);
    check("rst_Readdata_o", Readdata_o, 32'd0);
    check("rst_ALUresult_o", ALUresult_o, 32'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    // pass-through ADD
    sb.push_back(mk(1, 0, 32'h55, 5, 0, 0));
    issue(0, 0, 1, 0, 3'b000, 32'h55, 32'h0, 5, 0, -1);
    settle();
    check("pass_stall", 32'(stall_cnt), 32'd0);
    check("pass_lat", 32'(lat), 32'd1);

    // LB, ack in first BUSY cycle
    sb.push_back(mk(1, 1, 32'h103, 7, 32'hFFFF_FF80, 0));
    issue(1, 0, 1, 1, 3'b000, 32'h103, 32'h0, 7, 32'h80AA_BBCC, 0);
    settle();
    check("lb_addr", cap_addr, 32'h100);
    check("lb_be", 32'(cap_be), 32'h8);
    check("lb_we", 32'(cap_we), 32'd0);
    check("lb_stall", 32'(stall_cnt), 32'd1);
    check("lb_req", 32'(req_cnt), 32'd1);
    check("lb_lat", 32'(lat), 32'd2);

    // LHU, 3-cycle ack delay: ack lands on the timeout terminal count and wins
    sb.push_back(mk(1, 1, 32'h202, 8, 32'h0000_9ABC, 0));
    issue(1, 0, 1, 1, 3'b101, 32'h202, 32'h0, 8, 32'h9ABC_1234, 3);
    settle();
    check("lhu_stall", 32'(stall_cnt), 32'd4);
    check("lhu_req", 32'(req_cnt), 32'd4);
    check("lhu_err", 32'(err_cnt), 32'd0);
    check("lhu_lat", 32'(lat), 32'd5);

    // SB
    sb.push_back(mk(0, 0, 32'h41, 0, 32'h0, 0));
    issue(0, 1, 0, 0, 3'b000, 32'h41, 32'h1234_56EF, 0, 32'h0, 1);
    settle();
    check("sb_we", 32'(cap_we), 32'd1);
    check("sb_be", 32'(cap_be), 32'h2);
    check("sb_wdata", cap_wdata, 32'hEFEF_EFEF);
    check("sb_addr", cap_addr, 32'h40);

    // misaligned LW
    sb.push_back(mk(0, 1, 32'h6, 9, 32'h0, 1));
    issue(1, 0, 1, 1, 3'b010, 32'h6, 32'h0, 9, 32'h0, 0);
    settle();
    check("mis_req", 32'(req_cnt), 32'd0);
    check("mis_err", 32'(err_cnt), 32'd1);
    check("mis_stall", 32'(stall_cnt), 32'd0);

    // illegal store funct3
    sb.push_back(mk(0, 0, 32'h10, 0, 32'h0, 1));
    issue(0, 1, 0, 0, 3'b100, 32'h10, 32'hFFFF_FFFF, 0, 32'h0, 0);
    settle();
    check("ill_req", 32'(req_cnt), 32'd0);
    check("ill_err", 32'(err_cnt), 32'd1);

    // timeout (TIMEOUT = 4), no ack
    sb.push_back(mk(0, 1, 32'h300, 10, 32'h0, 1));
    issue(1, 0, 1, 1, 3'b010, 32'h300, 32'h0, 10, 32'h0, -1);
    settle();
    check("tmo_req", 32'(req_cnt), 32'd4);
    check("tmo_stall", 32'(stall_cnt), 32'd4);
    check("tmo_err", 32'(err_cnt), 32'd1);
    check("tmo_lat", 32'(lat), 32'd5);

    // assorted loads
    for (int k = 0; k < 10; k++) begin
      f3 = ld_f3[k % 5];
      lane = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) lane = lane & 2'b10;
      if (f3[1:0] == 2'b10) lane = 2'b00;
      a = ($urandom & 32'hFFFF_FFFC) | 32'(lane);
      w = $urandom;
      d = $urandom_range(0, 2);
      sb.push_back(mk(1, 1, a, 5'(k + 1), m_load(f3, lane, w), 0));
      issue(1, 0, 1, 1, f3, a, 32'h0, 5'(k + 1), w, d);
      settle();
      check("ld_lat", 32'(lat), 32'(2 + d));
      check("ld_be", 32'(cap_be), 32'(m_be(f3[1:0], lane)));
    end

    // assorted stores
    for (int k = 0; k < 6; k++) begin
      f3 = 3'(k % 3);
      lane = 2'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) lane = lane & 2'b10;
      if (f3[1:0] == 2'b10) lane = 2'b00;
      a = ($urandom & 32'hFFFF_FFFC) | 32'(lane);
      w = $urandom;
      sb.push_back(mk(0, 0, a, 0, 32'h0, 0));
      issue(0, 1, 0, 0, f3, a, w, 0, 32'h0, $urandom_range(0, 2));
      settle();
      check("st_be", 32'(cap_be), 32'(m_be(f3[1:0], lane)));
      check("st_wdata", cap_wdata, m_wd(f3[1:0], w));
      check("st_addr", cap_addr, {a[31:2], 2'b00});
    end

    // spurious ack in IDLE is ignored
    @(posedge clk_i); #1 spur = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 spur = 1'b0;
    check("spur_req", 32'(mem_req_o), 32'd0);
    sb.push_back(mk(1, 0, 32'hABCD, 3, 32'h0, 0));
    issue(0, 0, 1, 0, 3'b000, 32'hABCD, 32'h0, 3, 32'h0, -1);
    settle();
    check("spur_pass_lat", 32'(lat), 32'd1);

    // async reset mid-BUSY: request and in-flight instruction dropped at once
    @(posedge clk_i); #1;
    ack_dly = -1;
    valid_i = 1'b1; MemRead_i = 1'b1; RegWrite_i = 1'b1; funct3_i = 3'b010;
    ALUresult_i = 32'h500; INS_11_7_i = 5'd12;
    repeat (3) @(negedge clk_i);
    #3;
    check("busy_before_rst", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    valid_i = 1'b0; MemRead_i = 1'b0; RegWrite_i = 1'b0;
    #1;
    check("rst_mid_req", 32'(mem_req_o), 32'd0);
    check("rst_mid_valid", 32'(valid_o), 32'd0);
    check("rst_mid_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #2 rst_i = 1'b0;
    sb.push_back(mk(1, 0, 32'h77, 4, 32'h0, 0));
    issue(0, 0, 1, 0, 3'b000, 32'h77, 32'h0, 4, 32'h0, -1);
    settle();
    check("post_rst_lat", 32'(lat), 32'd1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
